// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide, 32 CALC cycles then FIX.
// In: CLK, RST_N, START, FUNCT3, OP_A, OP_B, KILL. Out: BUSY, DONE, RESULT.
module muldiv_sequencer (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] OP_A,
  input  logic [31:0] OP_B,
  input  logic        KILL,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [2:0]  fn;
  logic [5:0]  count;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mag;
  logic [31:0] raw_a;
  logic        neg;
  logic        divz;
  logic        ovf;

  logic        is_div;
  logic        sgn_a;
  logic        sgn_b;
  logic        neg_a;
  logic        neg_b;
  logic        in_neg;
  logic        in_ovf;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  always_comb begin
    is_div = FUNCT3[2];
    sgn_a  = is_div ? ~FUNCT3[0]
                    : (FUNCT3[1:0] == 2'b01) ||
                      (FUNCT3[1:0] == 2'b10);
    sgn_b  = is_div ? ~FUNCT3[0]
                    : (FUNCT3[1:0] == 2'b01);
    neg_a  = sgn_a & OP_A[31];
    neg_b  = sgn_b & OP_B[31];
    abs_a  = neg_a ? -OP_A : OP_A;
    abs_b  = neg_b ? -OP_B : OP_B;
    // remainder takes the dividend sign
    in_neg = (is_div && FUNCT3[1]) ? neg_a
                                   : neg_a ^ neg_b;
    in_ovf = is_div & ~FUNCT3[0] &
             (OP_A == 32'h8000_0000) &
             (OP_B == 32'hffff_ffff);
  end

  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [32:0] div_dif;

  always_comb begin
    mul_sum = {1'b0, hi} +
              (lo[0] ? {1'b0, mag} : 33'd0);
    div_sh  = {hi, lo[31]};
    div_dif = div_sh - {1'b0, mag};
  end

  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fix_res;

  always_comb begin
    prod    = neg ? -{hi, lo} : {hi, lo};
    quo     = neg ? -lo : lo;
    rem     = neg ? -hi : hi;
    fix_res = rem;
    if (!fn[2])
      fix_res = (fn[1:0] == 2'b00) ? prod[31:0]
                                   : prod[63:32];
    else if (divz)
      fix_res = fn[1] ? raw_a : 32'hffff_ffff;
    else if (ovf)
      fix_res = fn[1] ? 32'd0 : 32'h8000_0000;
    else if (!fn[1])
      fix_res = quo;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      fn     <= '0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      mag    <= '0;
      raw_a  <= '0;
      neg    <= 1'b0;
      divz   <= 1'b0;
      ovf    <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START && !KILL) begin
            fn    <= FUNCT3;
            raw_a <= OP_A;
            neg   <= in_neg;
            divz  <= (OP_B == 32'd0);
            ovf   <= in_ovf;
            count <= '0;
            hi    <= '0;
            // mul: mag=multiplicand, lo=multiplier
            // div: mag=divisor, lo=dividend
            mag   <= is_div ? abs_b : abs_a;
            lo    <= is_div ? abs_a : abs_b;
            BUSY  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (KILL) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            if (fn[2]) begin
              if (!div_dif[32]) begin
                hi <= div_dif[31:0];
                lo <= {lo[30:0], 1'b1};
              end else begin
                hi <= div_sh[31:0];
                lo <= {lo[30:0], 1'b0};
              end
            end else begin
              hi <= mul_sum[32:1];
              lo <= {mul_sum[0], lo[31:1]};
            end
            count <= count + 6'd1;
            if (count == 6'd31)
              state <= FIX;
          end
        end
        FIX: begin
          BUSY  <= 1'b0;
          state <= IDLE;
          if (!KILL) begin
            RESULT <= fix_res;
            DONE   <= 1'b1;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed + random checks of muldiv_sequencer
// against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        KILL = 1'b0;
  logic [2:0]  FUNCT3 = '0;
  logic [31:0] OP_A = '0;
  logic [31:0] OP_B = '0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  muldiv_sequencer dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .FUNCT3 (FUNCT3),
    .OP_A   (OP_A),
    .OP_B   (OP_B),
    .KILL   (KILL),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(
    input logic [2:0] f,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa;
    longint sb;
    longint ub;
    logic [63:0] p;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ov = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    p = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin
        p = {32'h0, a} * {32'h0, b};
        return p[63:32];
      end
      3'd4: begin
        if (b == 0) return 32'hffff_ffff;
        if (ov) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hffff_ffff;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic quiet(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (DONE) dones++;
    end
  endtask

  task automatic run_op(
    input string tag,
    input logic [2:0] f,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] exp
  );
    int n;
    logic bz;
    FUNCT3 = f;
    OP_A = a;
    OP_B = b;
    START = 1'b1;
    tick();
    START = 1'b0;
    FUNCT3 = 3'($urandom);
    OP_A = $urandom;
    OP_B = $urandom;
    chk({tag, "/busy0"}, {31'b0, BUSY}, 32'd1);
    n = 0;
    bz = 1'b1;
    while (!DONE && n < 40) begin
      if (n == 5) START = 1'b1;
      tick();
      n++;
      START = 1'b0;
      if (!DONE) bz &= BUSY;
    end
    chk({tag, "/lat"}, 32'(n), 32'd33);
    chk({tag, "/busyrun"}, {31'b0, bz}, 32'd1);
    chk({tag, "/res"}, RESULT, exp);
    chk({tag, "/busydn"}, {31'b0, BUSY}, 32'd0);
    tick();
    chk({tag, "/pulse"}, {31'b0, DONE}, 32'd0);
    chk({tag, "/hold"}, RESULT, exp);
  endtask

  initial begin
    int n;
    int d;
    logic [2:0] f;
    logic [31:0] a;
    logic [31:0] b;

    tick();
    tick();
    chk("rst/busy", {31'b0, BUSY}, 32'd0);
    chk("rst/done", {31'b0, DONE}, 32'd0);
    chk("rst/res", RESULT, 32'd0);
    RST_N = 1'b1;
    tick();

    run_op("mul", 3'd0, 32'd7, 32'hffff_fffd, 32'hffff_ffeb);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000);
    run_op("mulhu", 3'd3, 32'hffff_ffff, 32'hffff_ffff,
           32'hffff_fffe);
    run_op("mulhsu", 3'd2, 32'hffff_ffff, 32'hffff_ffff,
           32'hffff_ffff);
    run_op("div", 3'd4, 32'hffff_fff9, 32'd2, 32'hffff_fffd);
    run_op("rem", 3'd6, 32'hffff_fff9, 32'd2, 32'hffff_ffff);
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14);
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2);
    run_op("divu0", 3'd5, 32'd100, 32'd0, 32'hffff_ffff);
    run_op("remu0", 3'd7, 32'd100, 32'd0, 32'd100);
    run_op("div0", 3'd4, 32'hffff_fff9, 32'd0, 32'hffff_ffff);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hffff_ffff,
           32'h8000_0000);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hffff_ffff, 32'd0);

    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = b & 32'hf;
        2: begin a = 32'h8000_0000; b = 32'hffff_ffff; end
        3: a = a & 32'hff;
        default: ;
      endcase
      run_op("rand", f, a, b, model(f, a, b));
    end

    // START held high across two operations
    FUNCT3 = 3'd0;
    OP_A = 32'h0001_2345;
    OP_B = 32'h0000_0010;
    START = 1'b1;
    tick();
    OP_A = $urandom;
    OP_B = $urandom;
    n = 0;
    while (!DONE && n < 40) begin tick(); n++; end
    chk("b2b/lat1", 32'(n), 32'd33);
    chk("b2b/res1", RESULT, 32'h0012_3450);
    FUNCT3 = 3'd5;
    OP_A = 32'd1000;
    OP_B = 32'd7;
    tick();
    chk("b2b/busy2", {31'b0, BUSY}, 32'd1);
    chk("b2b/done2", {31'b0, DONE}, 32'd0);
    OP_A = $urandom;
    OP_B = $urandom;
    n = 0;
    while (!DONE && n < 40) begin tick(); n++; end
    START = 1'b0;
    chk("b2b/lat2", 32'(n), 32'd33);
    chk("b2b/res2", RESULT, 32'd142);
    quiet(40, d);
    chk("b2b/extra", 32'(d), 32'd0);

    // KILL at CALC cycle 10
    FUNCT3 = 3'd4;
    OP_A = 32'd12345;
    OP_B = 32'd17;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    KILL = 1'b1;
    tick();
    KILL = 1'b0;
    chk("killc/busy", {31'b0, BUSY}, 32'd0);
    quiet(40, d);
    chk("killc/done", 32'(d), 32'd0);
    chk("killc/res", RESULT, 32'd142);

    // KILL with START in IDLE
    START = 1'b1;
    KILL = 1'b1;
    tick();
    START = 1'b0;
    KILL = 1'b0;
    chk("killi/busy", {31'b0, BUSY}, 32'd0);
    quiet(40, d);
    chk("killi/done", 32'(d), 32'd0);

    // KILL in the FIX cycle
    FUNCT3 = 3'd6;
    OP_A = 32'd99;
    OP_B = 32'd10;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 32; i++) tick();
    chk("killf/busyfix", {31'b0, BUSY}, 32'd1);
    KILL = 1'b1;
    tick();
    KILL = 1'b0;
    chk("killf/done", {31'b0, DONE}, 32'd0);
    chk("killf/busy", {31'b0, BUSY}, 32'd0);
    quiet(10, d);
    chk("killf/late", 32'(d), 32'd0);
    chk("killf/res", RESULT, 32'd142);

    // asynchronous reset mid-CALC
    FUNCT3 = 3'd3;
    OP_A = 32'hdead_beef;
    OP_B = 32'h1234_5678;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst/busy", {31'b0, BUSY}, 32'd0);
    chk("arst/done", {31'b0, DONE}, 32'd0);
    chk("arst/res", RESULT, 32'd0);
    tick();
    RST_N = 1'b1;
    quiet(40, d);
    chk("arst/nodone", 32'(d), 32'd0);
    chk("arst/idle", {31'b0, BUSY}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
